// File: rtl/keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_pkg
// Description : Shared definitions for the 4x4 keypad scanner: scanner FSM
//               state encoding, register word offsets relative to BASE,
//               register bit positions and a lowest-low-row helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_t;

  // Word offsets from BASE
  localparam logic [31:0] c_reg_data_off = 32'd0;
  localparam logic [31:0] c_reg_stat_off = 32'd1;

  // Bit positions inside the read words / status write word
  localparam int c_valid_bit   = 8;
  localparam int c_ovf_bit     = 8;
  localparam int c_ovf_clr_bit = 8;

  // Index of the lowest-numbered active-low row; only meaningful when at
  // least one row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_fifo
// Description : Small synchronous FIFO for key codes. Pointers carry one
//               extra wrap bit so full/empty are told apart by the MSBs.
//               A push while full is accepted only if a pop happens on the
//               same edge.
// Ports       : clk, reset_n (async active-low), push/push_data, pop,
//               pop_data (head entry), full, empty, count (occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : Memory-mapped 4x4 matrix keypad scanner. Drives one
//               active-low column per dwell, samples synchronised rows on the
//               last dwell cycle, debounces press and release, and queues one
//               4-bit code {row,col} per accepted press.
// Ports       : clk, reset_n (async active-low)
//               enable, rw, addr, data : CPU bus (rw=1 write)
//               q    : registered read data
//               col  : active-low column drive
//               row  : active-low asynchronous row sense
//               irq  : high while the code FIFO is non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h20,
  parameter int          SCAN_DIV   = 1024,
  parameter int          DEBOUNCE   = 4,     // must be >= 2
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic        irq
);

  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW   = $clog2(DEBOUNCE + 1);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] c_dwell_last = DW'(SCAN_DIV - 1);
  // The stable counter hits DEBOUNCE on the edge where it currently holds
  // DEBOUNCE-1, so that is the value compared against.
  localparam logic [CW-1:0] c_deb_last   = CW'(DEBOUNCE - 1);

  scan_state_t   r_state, w_state_nx;
  logic [3:0]    r_row_meta, r_row_sync;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx, w_col_idx_nx;
  logic [1:0]    r_cand_col, w_cand_col_nx;
  logic [1:0]    r_cand_row, w_cand_row_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          w_push;
  logic          w_end_dwell;
  logic          r_ovf;
  logic [31:0]   r_q;

  logic            w_full, w_empty, w_pop;
  logic [3:0]      w_head;
  logic [CNTW-1:0] w_count;

  logic w_rd_data, w_rd_stat, w_ovf_clr, w_ovf_set;
  logic w_unused_data;

  // --------------------------------------------------------------------------
  // Row synchroniser and dwell timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
      r_dwell    <= '0;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
      r_dwell    <= (r_dwell == c_dwell_last) ? '0 : r_dwell + 1'b1;
    end
  end

  assign w_end_dwell = (r_dwell == c_dwell_last);

  // --------------------------------------------------------------------------
  // Scanner FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_SCAN;
      r_col_idx  <= 2'd0;
      r_cand_col <= 2'd0;
      r_cand_row <= 2'd0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_col_idx  <= w_col_idx_nx;
      r_cand_col <= w_cand_col_nx;
      r_cand_row <= w_cand_row_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_col_idx_nx  = r_col_idx;
    w_cand_col_nx = r_cand_col;
    w_cand_row_nx = r_cand_row;
    w_cnt_nx      = r_cnt;
    w_push        = 1'b0;
    if (w_end_dwell) begin
      case (r_state)
        ST_SCAN: begin
          if (&r_row_sync) begin
            w_col_idx_nx = r_col_idx + 2'd1;
          end else begin
            w_cand_col_nx = r_col_idx;
            w_cand_row_nx = lowest_low(r_row_sync);
            w_cnt_nx      = CW'(1);
            w_state_nx    = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!r_row_sync[r_cand_row]) begin
            if (r_cnt == c_deb_last) begin
              w_push     = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = ST_HELD;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end else begin
            w_cnt_nx     = '0;
            w_col_idx_nx = r_col_idx + 2'd1;
            w_state_nx   = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Any low row (including a second key) restarts the release count.
          if (&r_row_sync) begin
            if (r_cnt == c_deb_last) begin
              w_cnt_nx     = '0;
              w_col_idx_nx = r_col_idx + 2'd1;
              w_state_nx   = ST_SCAN;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        default: begin
          w_cnt_nx   = '0;
          w_state_nx = ST_SCAN;
        end
      endcase
    end
  end

  assign col = ~(4'b0001 << r_col_idx);

  // --------------------------------------------------------------------------
  // Bus decode, overflow flag and read data register
  // --------------------------------------------------------------------------
  assign w_rd_data = enable && !rw && (addr == BASE + c_reg_data_off);
  assign w_rd_stat = enable && !rw && (addr == BASE + c_reg_stat_off);
  assign w_ovf_clr = enable && rw && (addr == BASE + c_reg_stat_off) &&
                     data[c_ovf_clr_bit];
  assign w_pop     = w_rd_data && !w_empty;
  // A push into a full FIFO is only lost when no pop frees a slot that edge.
  assign w_ovf_set = w_push && w_full && !w_pop;

  assign w_unused_data = ^{data[31:9], data[7:0]};

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({r_cand_row, r_cand_col}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_q   <= '0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;

      if (w_rd_data) begin
        r_q <= '0;
        if (!w_empty) begin
          r_q[c_valid_bit] <= 1'b1;
          r_q[3:0]         <= w_head;
        end
      end else if (w_rd_stat) begin
        r_q            <= '0;
        r_q[c_ovf_bit] <= r_ovf;
        r_q[2:0]       <= 3'(w_count);
      end
    end
  end

  assign q   = r_q;
  assign irq = (w_count != '0);

endmodule
`default_nettype wire
